// File: rtl/seq_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cmp_pkg
//  Description : Shared constants for the sequential magnitude comparator.
//                Holds the FSM state encoding and the bit positions of the
//                one-hot result vector {gt, eq, lt}.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_cmp_pkg;

    // FSM state encoding (1 bit)
    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_RUN  = 1'b1;

    // One-hot result vector layout
    localparam int unsigned RES_W  = 3;
    localparam int unsigned RES_GT = 2;
    localparam int unsigned RES_EQ = 1;
    localparam int unsigned RES_LT = 0;

endpackage : seq_cmp_pkg
`default_nettype wire

// File: rtl/seq_mag_cmp_digit_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : digit_cmp
//  Description : Purely combinational unsigned comparator for one DIGIT-bit
//                slice. Exactly one of gt/eq/lt is high for any input.
//  Ports       : x, y  [DIGIT-1:0]  digits to compare
//                gt, eq, lt         x > y, x == y, x < y
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (x > y);
    assign eq = (x == y);
    assign lt = (x < y);

endmodule : digit_cmp
`default_nettype wire

// File: rtl/seq_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mag_cmp
//  Description : Sequential magnitude comparator. Compares two WIDTH-bit
//                operands MSB-first, DIGIT bits per clock, stopping at the
//                first differing digit. Supports unsigned and two's-complement
//                compares with a start/busy/done handshake.
//  Ports       : clk, rst_n        clock, async active-low reset
//                start             request a compare (accepted only in IDLE)
//                signed_mode       1 = two's complement, 0 = unsigned
//                a, b  [WIDTH-1:0] operands, sampled with start
//                busy              compare in progress
//                done              one-cycle pulse, result valid
//                gt, eq, lt        result, held until the next accepted start
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_cmp
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int c_NDIG  = WIDTH / DIGIT;
    localparam int c_CNT_W = $clog2(c_NDIG + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_NDIG);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_param_check
            $fatal(1, "seq_mag_cmp: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [RES_W-1:0]   r_res, w_res_nxt;
    logic               r_done, w_done_nxt;
    logic               w_dgt_gt, w_dgt_eq, w_dgt_lt;
    logic               w_last;

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .x  (r_a[WIDTH-1 -: DIGIT]),
        .y  (r_b[WIDTH-1 -: DIGIT]),
        .gt (w_dgt_gt),
        .eq (w_dgt_eq),
        .lt (w_dgt_lt)
    );

    // The compare finishes on a differing digit or on the final digit
    assign w_last = !w_dgt_eq || (r_cnt == c_CNT_ONE);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath next-value logic ----------------
    always_comb begin
        w_a_nxt    = r_a;
        w_b_nxt    = r_b;
        w_cnt_nxt  = r_cnt;
        w_res_nxt  = r_res;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto
                    // offset binary, so an unsigned compare orders it right.
                    w_a_nxt            = a;
                    w_b_nxt            = b;
                    w_a_nxt[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    w_b_nxt[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    w_cnt_nxt          = c_CNT_LOAD;
                    w_res_nxt          = '0;
                end
            end
            ST_RUN: begin
                if (!w_dgt_eq) begin
                    w_res_nxt[RES_GT] = w_dgt_gt;
                    w_res_nxt[RES_LT] = w_dgt_lt;
                    w_done_nxt        = 1'b1;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_res_nxt[RES_EQ] = 1'b1;
                    w_done_nxt        = 1'b1;
                end else begin
                    w_a_nxt   = r_a << DIGIT;
                    w_b_nxt   = r_b << DIGIT;
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath / result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_done <= 1'b0;
        end else begin
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_cnt  <= w_cnt_nxt;
            r_res  <= w_res_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign gt   = r_res[RES_GT];
    assign eq   = r_res[RES_EQ];
    assign lt   = r_res[RES_LT];

endmodule : seq_mag_cmp
`default_nettype wire

// File: tb/tb_seq_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mag_cmp
//  Description : Self-checking bench for seq_mag_cmp (WIDTH=8, DIGIT=2).
//                Table of directed vectors plus hand-written handshake,
//                reset-abort and back-to-back sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_cmp;

    localparam int c_WIDTH = 8;
    localparam int c_DIGIT = 2;
    localparam int c_NVEC  = 12;
    localparam int c_TMO   = 20;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               signed_mode;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic               busy, done, gt, eq, lt;

    int n_checks;
    int n_errors;

    // expected result encoded as {gt, eq, lt}
    localparam logic [2:0] c_GT = 3'b100;
    localparam logic [2:0] c_EQ = 3'b010;
    localparam logic [2:0] c_LT = 3'b001;

    typedef struct {
        logic               sm;
        logic [c_WIDTH-1:0] a;
        logic [c_WIDTH-1:0] b;
        logic [2:0]         res;
        int                 lat;
    } vec_t;

    vec_t vecs [c_NVEC];

    seq_mag_cmp #(
        .WIDTH (c_WIDTH),
        .DIGIT (c_DIGIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a start request at the falling edge; return #1 after the sampling edge.
    task automatic start_op(input logic sm, input logic [c_WIDTH-1:0] va, input logic [c_WIDTH-1:0] vb);
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sm;
        a           = va;
        b           = vb;
        @(posedge clk);
        #1;
        start       = 1'b0;
        // operands may change freely after the start cycle
        a           = ~va;
        b           = ~vb;
        signed_mode = ~sm;
    endtask

    // Wait up to c_TMO edges for done; checks latency (counted from now) and result.
    task automatic wait_done(input string name, input logic [2:0] res, input int lat);
        int k;
        k = 0;
        for (int i = 1; i <= c_TMO; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
            check({name, " busy_in_run"}, {31'd0, busy}, 32'd1);
            check({name, " res_cleared"}, {29'd0, gt, eq, lt}, 32'd0);
        end
        check({name, " latency"}, k, lat);
        check({name, " result"}, {29'd0, gt, eq, lt}, {29'd0, res});
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_after(input string name, input logic [2:0] res);
        @(posedge clk);
        #1;
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, " result_held"}, {29'd0, gt, eq, lt}, {29'd0, res});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;

        //                sm    a      b      result lat
        vecs[0]  = '{1'b0, 8'hA5, 8'h5A, c_GT, 1};
        vecs[1]  = '{1'b0, 8'h3C, 8'h3C, c_EQ, 4};
        vecs[2]  = '{1'b0, 8'h12, 8'h13, c_LT, 4};
        vecs[3]  = '{1'b1, 8'h80, 8'h01, c_LT, 1};
        vecs[4]  = '{1'b0, 8'h80, 8'h01, c_GT, 1};
        vecs[5]  = '{1'b1, 8'hFF, 8'h01, c_LT, 1};
        vecs[6]  = '{1'b1, 8'h7F, 8'h80, c_GT, 1};
        vecs[7]  = '{1'b0, 8'h01, 8'h00, c_GT, 4};
        vecs[8]  = '{1'b1, 8'hFE, 8'hFF, c_LT, 4};
        vecs[9]  = '{1'b0, 8'h00, 8'hFF, c_LT, 1};
        vecs[10] = '{1'b0, 8'h0C, 8'h08, c_GT, 3};
        vecs[11] = '{1'b0, 8'h20, 8'h10, c_GT, 2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", {27'd0, busy, done, gt, eq, lt}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < c_NVEC; i++) begin
            start_op(vecs[i].sm, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d busy_after_start", i), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d res_cleared_at_start", i), {29'd0, gt, eq, lt}, 32'd0);
            wait_done($sformatf("v%0d", i), vecs[i].res, vecs[i].lat - 1 + 1);
            check_after($sformatf("v%0d", i), vecs[i].res);
        end

        // Start while busy is ignored: 0x00 vs 0x03 differs only in the last digit
        start_op(1'b0, 8'h00, 8'h03);
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_ign busy", {31'd0, busy}, 32'd1);
        wait_done("busy_ign", c_LT, 2);
        check_after("busy_ign", c_LT);
        check("busy_ign no_relaunch", {31'd0, busy}, 32'd0);

        // Start on the done cycle is ignored
        start_op(1'b0, 8'h3C, 8'h3C);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_ign done", {31'd0, done}, 32'd1);
        check("done_ign result", {29'd0, gt, eq, lt}, {29'd0, c_EQ});
        check_after("done_ign", c_EQ);
        check("done_ign not_busy", {31'd0, busy}, 32'd0);

        // Reset mid-operation aborts with no done
        start_op(1'b0, 8'h11, 8'h11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort async_clear", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort held_in_reset", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort no_done", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        start_op(1'b0, 8'h01, 8'h00);
        wait_done("after_abort", c_GT, 4);

        // Back-to-back: start in the first IDLE cycle after done
        @(negedge clk);
        check("b2b old_held_in_idle", {29'd0, gt, eq, lt}, {29'd0, c_GT});
        start       = 1'b1;
        signed_mode = 1'b1;
        a           = 8'h80;
        b           = 8'h7F;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        wait_done("b2b", c_LT, 1);
        check_after("b2b", c_LT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_mag_cmp
`default_nettype wire
